// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants, state encoding and helpers for the FIFO
//               burst reader and its skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_LEN_W  = 8;

    localparam int SKID_DEPTH = 4;
    localparam int SKID_PTR_W = 2;
    localparam int SKID_OCC_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // True when one more byte can be popped without overrunning the skid
    // buffer: bytes already held plus the one still in flight from the FIFO
    // must leave a free slot.
    function automatic logic credit_ok(input logic [SKID_OCC_W-1:0] occ,
                                       input logic                  inflight);
        logic [3:0] used;
        used = {1'b0, occ} + {3'b000, inflight};
        return (used < 4'(SKID_DEPTH));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fifo_skid_buf
// Description : 4-entry circular skid buffer. The head entry drives rdata;
//               occ reports the number of stored entries.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_W = fifo_pkg::DEFAULT_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  rd,
    output logic [DATA_W-1:0]     rdata,
    output logic [SKID_OCC_W-1:0] occ
);

    logic [DATA_W-1:0]     r_mem [SKID_DEPTH];
    logic [SKID_PTR_W-1:0] r_wptr;
    logic [SKID_PTR_W-1:0] r_rptr;
    logic [SKID_OCC_W-1:0] r_occ;

    logic w_push;
    logic w_pop;

    // Writes into a full buffer and reads from an empty one are dropped so
    // the pointers can never cross.
    assign w_push = wr && (r_occ != SKID_OCC_W'(SKID_DEPTH));
    assign w_pop  = rd && (r_occ != '0);

    // Storage array; cleared on reset so the head reads 0 out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Write and read pointers; 2-bit arithmetic wraps 3 -> 0 naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
        end
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 3'd1;
                2'b01:   r_occ <= r_occ - 3'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign rdata = r_mem[r_rptr];
    assign occ   = r_occ;

endmodule
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_reader
// Description : Pulls a commanded number of bytes from a synchronous FIFO
//               (one-cycle read latency) and presents them on a valid/ready
//               stream, absorbing backpressure in a 4-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W = fifo_pkg::DEFAULT_DATA_W,
    parameter int LEN_W  = fifo_pkg::DEFAULT_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  remaining
);

    state_t r_state;
    state_t w_state_next;

    logic [LEN_W-1:0]      r_issue;
    logic [LEN_W-1:0]      r_remaining;
    logic                  r_inflight;
    logic                  r_done;

    logic                  w_rd_en;
    logic                  w_load;
    logic                  w_done_next;
    logic                  w_accept;
    logic [SKID_OCC_W-1:0] w_occ;

    assign m_valid  = (w_occ != '0);
    assign w_accept = m_valid && m_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, pop request and burst load. The pop depends only on state,
    // issue count, skid credit and fifo_empty -- never on m_ready.
    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        w_load       = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && (burst_len != '0)) begin
                    w_load       = 1'b1;
                    w_state_next = READ;
                end
            end
            READ: begin
                w_rd_en = !fifo_empty && (r_issue != '0) &&
                          credit_ok(w_occ, r_inflight);
                if (w_rd_en && (r_issue == LEN_W'(1))) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_accept && (r_remaining == LEN_W'(1))) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Issue counter (pops still owed) and remaining counter (beats still
    // owed downstream); both saturate at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issue     <= '0;
            r_remaining <= '0;
        end else begin
            if (w_load) begin
                r_issue <= burst_len;
            end else if (w_rd_en && (r_issue != '0)) begin
                r_issue <= r_issue - LEN_W'(1);
            end

            if (w_load) begin
                r_remaining <= burst_len;
            end else if (w_accept && (r_remaining != '0)) begin
                r_remaining <= r_remaining - LEN_W'(1);
            end
        end
    end

    // In-flight flag marks the cycle in which popped data is on fifo_data;
    // the done pulse follows the final handshake by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            r_done     <= w_done_next;
        end
    end

    fifo_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .wr    (r_inflight),
        .wdata (fifo_data),
        .rd    (w_accept),
        .rdata (m_data),
        .occ   (w_occ)
    );

    assign fifo_rd_en = w_rd_en;
    assign busy       = (r_state != IDLE);
    assign done       = r_done;
    assign remaining  = r_remaining;

endmodule
`default_nettype wire
